// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types used by the branch predictor slice.
//   word_t               32-bit machine word (PCs, targets)
//   bp_state_t           2-bit direction counter state (SNT, WNT, WT, ST)
//   BTB_ENTRIES_DEFAULT  default number of direct-mapped BTB entries
//   BP_RESET_STATE       counter value after reset and on a lookup miss
//   BP_ALLOC_STATE       counter value written when an entry is allocated
//   bp_is_taken()        direction implied by a counter state
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // The encoding matters: bit 1 of the counter is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_t;

  localparam int BTB_ENTRIES_DEFAULT = 4;

  localparam bp_state_t BP_RESET_STATE = WNT;
  localparam bp_state_t BP_ALLOC_STATE = WT;

  function automatic logic bp_is_taken(input bp_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch-side lookup and resolve-side update signals of the
// branch predictor.
//   modport bp : predictor side (lookup/update inputs, prediction outputs)
//   modport tb : driver side (the pipeline or a testbench)
// Signals:
//   pc_if          fetch-stage PC to predict
//   freeze         hazard-unit freeze; blocks table updates
//   update_en      a resolved beq/bne is in the resolve stage
//   update_pc      PC of the resolved branch
//   update_taken   actual direction of the resolved branch
//   update_target  actual taken target of the resolved branch
//   predict_taken  fetch should redirect to predict_target
//   predict_target predicted next PC (0 when not predicting taken)
//   prediction     counter state for pc_if, consumed by the hazard unit
// ---------------------------------------------------------------------------
interface branch_predictor_if;
  import cpu_types_pkg::*;

  word_t       pc_if;
  logic        freeze;
  logic        update_en;
  word_t       update_pc;
  logic        update_taken;
  word_t       update_target;
  logic        predict_taken;
  word_t       predict_target;
  logic [1:0]  prediction;

  modport bp (
    input  pc_if,
    input  freeze,
    input  update_en,
    input  update_pc,
    input  update_taken,
    input  update_target,
    output predict_taken,
    output predict_target,
    output prediction
  );

  modport tb (
    output pc_if,
    output freeze,
    output update_en,
    output update_pc,
    output update_taken,
    output update_target,
    input  predict_taken,
    input  predict_target,
    input  prediction
  );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Combinational next-state for a 2-bit saturating direction counter.
//   cur    current counter state
//   taken  branch outcome: 1 steps toward ST, 0 steps toward SNT
//   nxt    next counter state (saturates at ST and SNT)
// ---------------------------------------------------------------------------
module sat_counter
  import cpu_types_pkg::*;
(
  input  bp_state_t cur,
  input  logic      taken,
  output bp_state_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup is purely combinational from pc_if; updates
// from the resolve stage are written on the rising edge of CLK.
// Ports:
//   CLK    sole clock, rising edge
//   nRST   asynchronous active-low reset; clears every entry
//   bus    branch_predictor_if.bp (lookup, update and prediction signals)
// Parameters:
//   BTB_ENTRIES  number of entries, power of two in 2..16
// Addressing: index = pc[log2(BTB_ENTRIES)+1:2], tag = pc[31:log2+2].
// ---------------------------------------------------------------------------
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic               CLK,
  input  logic               nRST,
  branch_predictor_if.bp     bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Entry storage; these arrays are the only state in the block.
  logic              valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
  word_t             target_q [BTB_ENTRIES];
  bp_state_t         cnt_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  bp_state_t         lk_cnt;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              upd_fire;
  bp_state_t         upd_cnt_next;

  // The byte-offset bits of a word-aligned PC carry no information.
  logic              unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_if[1:0], bus.update_pc[1:0]};

  assign lk_idx  = bus.pc_if[IDX_W+1:2];
  assign lk_tag  = bus.pc_if[31:IDX_W+2];
  assign upd_idx = bus.update_pc[IDX_W+1:2];
  assign upd_tag = bus.update_pc[31:IDX_W+2];

  // Lookup reads the registered arrays directly, so a same-cycle update to
  // the same index is only visible after the edge that writes it.
  always_comb begin
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_cnt = lk_hit ? cnt_q[lk_idx] : BP_RESET_STATE;
  end

  always_comb begin
    bus.prediction     = lk_cnt;
    bus.predict_taken  = lk_hit && bp_is_taken(lk_cnt);
    bus.predict_target = bus.predict_taken ? target_q[lk_idx] : 32'h0;
  end

  // Update-side hit detection and counter step; the single sat_counter
  // serves whichever entry the resolving branch maps to.
  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_fire = bus.update_en && !bus.freeze;
  end

  sat_counter u_sat_counter (
    .cur   (cnt_q[upd_idx]),
    .taken (bus.update_taken),
    .nxt   (upd_cnt_next)
  );

  // Table write. Reset wins over any update on the same edge. A taken miss
  // allocates and overwrites whatever aliased into that index; a not-taken
  // miss is ignored so cold branches do not evict useful entries.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        cnt_q[i]    <= BP_RESET_STATE;
      end
    end else if (upd_fire) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= upd_cnt_next;
        if (bus.update_taken) begin
          target_q[upd_idx] <= bus.update_target;
        end
      end else if (bus.update_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bus.update_target;
        cnt_q[upd_idx]    <= BP_ALLOC_STATE;
      end
    end
  end

endmodule
